// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : store_buffer
//  Purpose  : Posted-write FIFO between the MEM stage and the data-memory port,
//             with an in-order req/ack drain and a word-granular load-hazard flag.
//  Revision : 1.0
// ============================================================================
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_wdata,
    input  logic [3:0]               st_be,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_hazard,
    output logic                     mem_req,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int              c_pw      = $clog2(DEPTH);
    localparam int              c_cw      = c_pw + 1;
    localparam logic [c_cw-1:0] c_full    = c_cw'(DEPTH);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_pw-1:0] c_ptr_one = c_pw'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Only the word address is kept; byte offset is implied by the mask.
    logic [AW-3:0]    r_waddr [DEPTH];
    logic [DW-1:0]    r_wdata [DEPTH];
    logic [3:0]       r_be    [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_pw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic [c_cw-1:0]  w_count_nxt;
    state_t           r_state;
    logic             r_mem_req;
    logic             w_push;
    logic             w_pop;
    logic             w_hit;
    logic             w_unused;

    assign st_ready = (r_count != c_full);
    // Empty-mask stores are handshaken but never occupy an entry.
    assign w_push   = st_valid && st_ready && (st_be != 4'b0000);
    assign w_pop    = (r_state == ST_REQ) && mem_ack;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push) w_count_nxt = w_count_nxt + c_cnt_one;
        if (w_pop)  w_count_nxt = w_count_nxt - c_cnt_one;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_waddr[r_wr_ptr] <= st_addr[AW-1:2];
            r_wdata[r_wr_ptr] <= st_wdata;
            r_be[r_wr_ptr]    <= st_be;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_valid   <= '0;
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + c_ptr_one;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + c_ptr_one;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        r_state   <= ST_REQ;
                        r_mem_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // Stay in REQ for back-to-back drain while anything remains.
                    if (w_pop && (w_count_nxt == '0)) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_waddr[i] == ld_addr[AW-1:2])) w_hit = 1'b1;
        end
    end

    assign ld_hazard = ld_valid && w_hit;
    assign mem_req   = r_mem_req;
    assign mem_addr  = {r_waddr[r_rd_ptr], 2'b00};
    assign mem_wdata = r_wdata[r_rd_ptr];
    assign mem_be    = r_be[r_rd_ptr];
    assign count     = r_count;
    assign w_unused  = ^{st_addr[1:0], ld_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_buffer
//  Purpose  : Directed bench for store_buffer; drained writes are checked
//             against a queue of expected transactions by a separate monitor.
//  Revision : 1.0
// ============================================================================
module tb_store_buffer;
    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_be;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_hazard;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [2:0]  count;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  b;
    } txn_t;

    txn_t sb[$];
    txn_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_be     (st_be),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_hazard (ld_hazard),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ack   (mem_ack),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        st_valid = 1'b1;
        st_addr  = a;
        st_wdata = d;
        st_be    = b;
    endtask

    task automatic expect_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        txn_t t;
        t.a = a;
        t.d = d;
        t.b = b;
        sb.push_back(t);
    endtask

    // A write completes at the edge where mem_req and mem_ack are both high.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ack) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_issue: got addr %0h expected no request", mem_addr);
            end else begin
                mon_e = sb.pop_front();
                chk("drain_addr", mem_addr, mon_e.a);
                chk("drain_data", mem_wdata, mon_e.d);
                chk("drain_be", {28'd0, mem_be}, {28'd0, mon_e.b});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] t2_addr [4];
    logic [31:0] t2_exp  [4];
    logic [31:0] t2_data [4];
    logic [3:0]  t2_be   [4];

    initial begin
        t2_addr = '{32'h0000_0010, 32'h0000_0024, 32'h0000_003A, 32'h0000_004C};
        t2_exp  = '{32'h0000_0010, 32'h0000_0024, 32'h0000_0038, 32'h0000_004C};
        t2_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        t2_be   = '{4'b0001, 4'b0010, 4'b1100, 4'b1111};

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_wdata = '0; st_be = '0;
        ld_valid = 1'b1; ld_addr = 32'h100; mem_ack = 1'b1;
        step(); step();
        chk("reset_count", {29'd0, count}, 32'd0);
        chk("reset_ready", {31'd0, st_ready}, 32'd1);
        chk("reset_req", {31'd0, mem_req}, 32'd0);
        chk("reset_hazard", {31'd0, ld_hazard}, 32'd0);
        rst_n = 1'b1; ld_valid = 1'b0;

        // Single store, ack held high throughout.
        drive_st(32'h100, 32'hAABB_CCDD, 4'b0011);
        expect_txn(32'h100, 32'hAABB_CCDD, 4'b0011);
        step();
        st_valid = 1'b0;
        chk("t1_count_push", {29'd0, count}, 32'd1);
        chk("t1_req_idle", {31'd0, mem_req}, 32'd0);
        step();
        chk("t1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_be", {28'd0, mem_be}, 32'h3);
        step();
        chk("t1_count_drained", {29'd0, count}, 32'd0);
        chk("t1_req_low", {31'd0, mem_req}, 32'd0);

        // Fill to full, reject a fifth store, then drain in order.
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_st(t2_addr[i], t2_data[i], t2_be[i]);
            expect_txn(t2_exp[i], t2_data[i], t2_be[i]);
            step();
        end
        chk("t2_count_full", {29'd0, count}, 32'd4);
        chk("t2_ready_full", {31'd0, st_ready}, 32'd0);
        drive_st(32'h5C, 32'h5555_5555, 4'b1111);
        step();
        st_valid = 1'b0;
        chk("t2_count_reject", {29'd0, count}, 32'd4);
        chk("t2_req_full", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_count_drain", {29'd0, count}, 32'(3 - k));
            chk("t2_req_drain", {31'd0, mem_req}, (k < 3) ? 32'd1 : 32'd0);
        end
        mem_ack = 1'b0;

        // Full buffer: pop with a waiting store, then push+pop on one edge, wrap pointers.
        for (int i = 0; i < 4; i++) begin
            drive_st(32'h300 + 32'(i * 16), 32'hA000_0000 + 32'(i), 4'b1111);
            expect_txn(32'h300 + 32'(i * 16), 32'hA000_0000 + 32'(i), 4'b1111);
            step();
        end
        chk("t3_count_full", {29'd0, count}, 32'd4);
        drive_st(32'h340, 32'hE000_000E, 4'b0101);
        mem_ack = 1'b1;
        step();
        chk("t3_pop_no_push", {29'd0, count}, 32'd3);
        expect_txn(32'h340, 32'hE000_000E, 4'b0101);
        step();
        chk("t3_push_pop", {29'd0, count}, 32'd3);
        chk("t3_req_hold", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b0;
        drive_st(32'h350, 32'hF000_000F, 4'b1010);
        expect_txn(32'h350, 32'hF000_000F, 4'b1010);
        step();
        st_valid = 1'b0;
        chk("t3_refill", {29'd0, count}, 32'd4);
        chk("t3_ready_full", {31'd0, st_ready}, 32'd0);
        mem_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_count_drain", {29'd0, count}, 32'(3 - k));
        end
        mem_ack = 1'b0;
        chk("t3_req_end", {31'd0, mem_req}, 32'd0);

        // Load hazard at word granularity.
        drive_st(32'h204, 32'hDEAD_BEEF, 4'b0001);
        ld_valid = 1'b1; ld_addr = 32'h206;
        #1;
        chk("t4_same_cycle", {31'd0, ld_hazard}, 32'd0);
        expect_txn(32'h204, 32'hDEAD_BEEF, 4'b0001);
        step();
        st_valid = 1'b0;
        #1;
        chk("t4_hit", {31'd0, ld_hazard}, 32'd1);
        ld_addr = 32'h208;
        #1;
        chk("t4_miss", {31'd0, ld_hazard}, 32'd0);
        ld_addr = 32'h204; ld_valid = 1'b0;
        #1;
        chk("t4_no_load", {31'd0, ld_hazard}, 32'd0);
        ld_valid = 1'b1;
        step();
        chk("t4_hit_inflight", {31'd0, ld_hazard}, 32'd1);
        chk("t4_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t4_after_ack", {31'd0, ld_hazard}, 32'd0);
        chk("t4_count", {29'd0, count}, 32'd0);
        ld_valid = 1'b0;

        // Empty byte mask is swallowed.
        drive_st(32'h500, 32'h1234_5678, 4'b0000);
        step();
        st_valid = 1'b0;
        chk("t5_count", {29'd0, count}, 32'd0);
        step();
        chk("t5_req1", {31'd0, mem_req}, 32'd0);
        step();
        chk("t5_req2", {31'd0, mem_req}, 32'd0);

        // Reset while draining discards everything, including the in-flight head.
        for (int i = 0; i < 3; i++) begin
            drive_st(32'h600 + 32'(i * 16), 32'hC000_0000 + 32'(i), 4'b1111);
            step();
        end
        st_valid = 1'b0;
        step();
        chk("t6_req_before", {31'd0, mem_req}, 32'd1);
        chk("t6_count_before", {29'd0, count}, 32'd3);
        rst_n = 1'b0; ld_valid = 1'b1; ld_addr = 32'h600;
        step();
        chk("t6_req", {31'd0, mem_req}, 32'd0);
        chk("t6_count", {29'd0, count}, 32'd0);
        chk("t6_ready", {31'd0, st_ready}, 32'd1);
        chk("t6_hazard", {31'd0, ld_hazard}, 32'd0);
        rst_n = 1'b1; ld_valid = 1'b0; mem_ack = 1'b1;
        repeat (4) step();
        chk("t6_req_after", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
